// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bus_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } resp_state_t;

    // Width of the wait-state counter; holds LATENCY-1 for LATENCY up to 15
    localparam int WCNT_W = 4;

    // Number of byte-offset address bits below the word index
    function automatic int off_width(input int bus_width);
        return $clog2(bus_width / 8);
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Word memory with one write port and one registered read port.
// Latency: read data registered one edge after rd_en; same-edge write to the read index is forwarded.
// Backpressure: none; the read register holds its value while rd_en is low.
module bus_mem_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [BUS_WIDTH-1:0]  wr_dat,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [BUS_WIDTH-1:0]  rd_dat
);

    logic [BUS_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Storage write; contents deliberately survive reset so preloaded images persist
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    // Registered read with write-first forwarding on an index collision
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            if (wr_en && (wr_idx == rd_idx)) begin
                rd_dat <= wr_dat;
            end else begin
                rd_dat <= mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/bus_mem_resp.sv
// Bus target: returns the addressed word after LATENCY wait states, flags out-of-range accesses.
// Latency: data and valid appear LATENCY edges after an address is first sampled as new.
// Backpressure: none; any address change drops valid and restarts the wait count.
module bus_mem_resp
    import bus_pkg::*;
#(
    parameter int AD_LEN     = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [AD_LEN-1:0]     bus_ad_i,
    input  logic                  load_en_i,
    input  logic [DEPTH_LOG2-1:0] load_ad_i,
    input  logic [BUS_WIDTH-1:0]  load_data_i,
    output logic [BUS_WIDTH-1:0]  bus_data_o,
    output logic                  bus_valid_o,
    output logic                  bus_err_o
);

    localparam int OFF_W  = off_width(BUS_WIDTH);
    localparam int IDX_HI = DEPTH_LOG2 + OFF_W - 1;
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(LATENCY - 1);

    resp_state_t           state;
    logic [AD_LEN-1:0]     last_ad;
    logic [WCNT_W-1:0]     wcnt;
    logic                  ad_changed;
    logic                  done;
    logic                  in_range;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [BUS_WIDTH-1:0]  rd_dat;

    assign ad_changed = (bus_ad_i != last_ad);
    assign in_range   = ~|last_ad[AD_LEN-1:IDX_HI+1];
    assign rd_idx     = last_ad[IDX_HI:OFF_W];

    // A data update happens on the completing WAIT edge and on every stable VALID edge
    assign done  = !ad_changed && ((state == VALID) || ((state == WAIT) && (wcnt == '0)));
    assign rd_en = done && in_range;

    // Out-of-range completions read as zero; err only changes on update edges, so this is stable
    assign bus_data_o = bus_err_o ? '0 : rd_dat;

    bus_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BUS_WIDTH  (BUS_WIDTH)
    ) u_mem (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .wr_en    (load_en_i),
        .wr_idx   (load_ad_i),
        .wr_dat   (load_data_i),
        .rd_en    (rd_en),
        .rd_idx   (rd_idx),
        .rd_dat   (rd_dat)
    );

    // Request FSM: capture address, count wait states, present and refresh the word
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= IDLE;
            last_ad     <= '0;
            wcnt        <= '0;
            bus_valid_o <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= WAIT;
                    last_ad     <= bus_ad_i;
                    wcnt        <= WCNT_LOAD;
                    bus_valid_o <= 1'b0;
                end
                WAIT: begin
                    if (ad_changed) begin
                        last_ad <= bus_ad_i;
                        wcnt    <= WCNT_LOAD;
                    end else if (wcnt == '0) begin
                        state       <= VALID;
                        bus_valid_o <= 1'b1;
                        bus_err_o   <= !in_range;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                VALID: begin
                    if (ad_changed) begin
                        state       <= WAIT;
                        last_ad     <= bus_ad_i;
                        wcnt        <= WCNT_LOAD;
                        bus_valid_o <= 1'b0;
                    end else begin
                        bus_err_o <= !in_range;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_resp.sv
// Directed bench for bus_mem_resp with LATENCY=2 and LATENCY=1 instances on shared inputs.
// Latency: checks exact edge counts from address capture to valid.
// Backpressure: exercises restart, back-to-back, out-of-range, collision and async reset.
module tb_bus_mem_resp;

    logic        clk;
    logic        reset_ni;
    logic [31:0] bus_ad;
    logic        load_en;
    logic [9:0]  load_ad;
    logic [31:0] load_data;
    logic [31:0] data2, data1;
    logic        valid2, valid1;
    logic        err2, err1;

    int n_cmp = 0;
    int n_err = 0;

    bus_mem_resp #(.AD_LEN(32), .BUS_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .bus_ad_i    (bus_ad),
        .load_en_i   (load_en),
        .load_ad_i   (load_ad),
        .load_data_i (load_data),
        .bus_data_o  (data2),
        .bus_valid_o (valid2),
        .bus_err_o   (err2)
    );

    bus_mem_resp #(.AD_LEN(32), .BUS_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .bus_ad_i    (bus_ad),
        .load_en_i   (load_en),
        .load_ad_i   (load_ad),
        .load_data_i (load_data),
        .bus_data_o  (data1),
        .bus_valid_o (valid1),
        .bus_err_o   (err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; samples and input changes happen 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] dat);
        load_en   = 1'b1;
        load_ad   = idx;
        load_data = dat;
        tick();
        load_en   = 1'b0;
    endtask

    initial begin
        reset_ni  = 1'b0;
        bus_ad    = $urandom;
        load_en   = 1'b0;
        load_ad   = '0;
        load_data = '0;

        // Reset held with random address
        tick();
        bus_ad = $urandom;
        tick();
        check("rst_data", data2, 32'h0);
        check("rst_valid", {31'b0, valid2}, 32'h0);
        check("rst_err", {31'b0, err2}, 32'h0);

        // Preload while in reset
        load(10'd0,    32'h0BAD_0000);
        load(10'd2,    32'hDEAD_BEEF);
        load(10'd3,    32'h3333_3333);
        load(10'd4,    32'h4444_4444);
        load(10'd1023, 32'hCAFE_F00D);
        check("rst_hold_valid", {31'b0, valid2}, 32'h0);

        // Basic read of 0x8
        bus_ad   = 32'h8;
        reset_ni = 1'b1;
        tick();
        check("basic_e0_valid", {31'b0, valid2}, 32'h0);
        tick();
        check("basic_e1_valid", {31'b0, valid2}, 32'h0);
        tick();
        check("basic_e2_valid", {31'b0, valid2}, 32'h1);
        check("basic_data", data2, 32'hDEAD_BEEF);
        check("basic_err", {31'b0, err2}, 32'h0);

        // Byte offset ignored: 0xB returns the same word
        bus_ad = 32'hB;
        tick();
        check("offs_drop_valid", {31'b0, valid2}, 32'h0);
        check("offs_hold_data", data2, 32'hDEAD_BEEF);
        tick();
        check("offs_e1_valid", {31'b0, valid2}, 32'h0);
        tick();
        check("offs_valid", {31'b0, valid2}, 32'h1);
        check("offs_data", data2, 32'hDEAD_BEEF);

        // Restart: 0x8 then 0xC one edge later
        bus_ad = 32'h8;
        tick();
        bus_ad = 32'hC;
        tick();
        check("restart_e0_valid", {31'b0, valid2}, 32'h0);
        tick();
        check("restart_e1_valid", {31'b0, valid2}, 32'h0);
        tick();
        check("restart_valid", {31'b0, valid2}, 32'h1);
        check("restart_data", data2, 32'h3333_3333);

        // Back-to-back: settle on 0x8 then switch to 0x10
        bus_ad = 32'h8;
        tick();
        tick();
        tick();
        check("b2b_first_data", data2, 32'hDEAD_BEEF);
        bus_ad = 32'h10;
        tick();
        check("b2b_drop_valid", {31'b0, valid2}, 32'h0);
        check("b2b_hold_data", data2, 32'hDEAD_BEEF);
        tick();
        check("b2b_e1_valid", {31'b0, valid2}, 32'h0);
        tick();
        check("b2b_valid", {31'b0, valid2}, 32'h1);
        check("b2b_data", data2, 32'h4444_4444);

        // Out of range 0x1000
        bus_ad = 32'h1000;
        tick();
        tick();
        tick();
        check("oor_valid", {31'b0, valid2}, 32'h1);
        check("oor_data", data2, 32'h0);
        check("oor_err", {31'b0, err2}, 32'h1);

        // Top word 0xFFC is in range
        bus_ad = 32'hFFC;
        tick();
        tick();
        tick();
        check("top_valid", {31'b0, valid2}, 32'h1);
        check("top_data", data2, 32'hCAFE_F00D);
        check("top_err", {31'b0, err2}, 32'h0);

        // Collision in VALID on index 2
        bus_ad = 32'h8;
        tick();
        tick();
        tick();
        check("coll_pre_data", data2, 32'hDEAD_BEEF);
        load(10'd2, 32'h1234_5678);
        check("coll_data", data2, 32'h1234_5678);
        check("coll_valid", {31'b0, valid2}, 32'h1);
        tick();
        check("coll_refresh_data", data2, 32'h1234_5678);

        // LATENCY=1: load on the completion edge is bypassed
        bus_ad = 32'h10;
        tick();
        check("l1_capture_valid", {31'b0, valid1}, 32'h0);
        load(10'd4, 32'hA5A5_A5A5);
        check("l1_valid", {31'b0, valid1}, 32'h1);
        check("l1_bypass_data", data1, 32'hA5A5_A5A5);
        check("l2_still_wait", {31'b0, valid2}, 32'h0);

        // Async reset mid-WAIT, no clock edge
        bus_ad = 32'hC;
        tick();
        reset_ni = 1'b0;
        #1;
        check("arst_data2", data2, 32'h0);
        check("arst_data1", data1, 32'h0);
        check("arst_valid2", {31'b0, valid2}, 32'h0);
        check("arst_err2", {31'b0, err2}, 32'h0);

        // After release, first request captures address 0
        bus_ad = 32'h0;
        tick();
        reset_ni = 1'b1;
        tick();
        tick();
        check("zero_e1_valid", {31'b0, valid2}, 32'h0);
        tick();
        check("zero_valid", {31'b0, valid2}, 32'h1);
        check("zero_data", data2, 32'h0BAD_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
